alu_ctrl_m: RTL and testbench

Second-generation ALU controller for the EX stage: decodes `ula_op`/`funct3`/`funct7` into the existing 4-bit single-cycle ALU operation code, and adds RV32M support. M-extension operations run on an iterative, XLEN-parametrised multiply/divide engine inside this block. While that engine is busy, the block stalls the pipeline and then returns the result with a one-cycle done strobe. It sits beside the single-cycle ALU; the EX-stage result mux selects `m_result` when `m_done` is high.

---
 rtl/alu_pkg.sv | 36 +++
 rtl/muldiv_iter.sv | 64 ++++++
 rtl/alu_ctrl_m.sv | 159 +++++++++++++++
 tb/tb_alu_ctrl_m.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared encodings for the EX-stage ALU controller: ALU op codes, decode fields and
// multiply/divide FSM states.
package alu_pkg;

  localparam logic [3:0] OpAdd  = 4'd0;
  localparam logic [3:0] OpSub  = 4'd1;
  localparam logic [3:0] OpXor  = 4'd2;
  localparam logic [3:0] OpOr   = 4'd3;
  localparam logic [3:0] OpAnd  = 4'd4;
  localparam logic [3:0] OpSll  = 4'd5;
  localparam logic [3:0] OpSrl  = 4'd6;
  localparam logic [3:0] OpSra  = 4'd7;
  localparam logic [3:0] OpSlt  = 4'd8;
  localparam logic [3:0] OpSltu = 4'd9;

  localparam logic [1:0] UlaAdd   = 2'b00;
  localparam logic [1:0] UlaSub   = 2'b01;
  localparam logic [1:0] UlaRtype = 2'b10;
  localparam logic [1:0] UlaRsvd  = 2'b11;

  localparam logic [6:0] F7Base   = 7'b0000000;
  localparam logic [6:0] F7Alt    = 7'b0100000;
  localparam logic [6:0] F7MulDiv = 7'b0000001;

  localparam logic [2:0] F3Mul    = 3'd0;
  localparam logic [2:0] F3Mulh   = 3'd1;
  localparam logic [2:0] F3Mulhsu = 3'd2;
  localparam logic [2:0] F3Mulhu  = 3'd3;
  localparam logic [2:0] F3Div    = 3'd4;
  localparam logic [2:0] F3Divu   = 3'd5;
  localparam logic [2:0] F3Rem    = 3'd6;
  localparam logic [2:0] F3Remu   = 3'd7;

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} m_state_e;

endpackage

// File: rtl/muldiv_iter.sv
// Unsigned iterative multiply (radix-2 shift-add) / restoring divide, one bit per cycle.
// acc holds {high, low} for multiply and {remainder, quotient} for divide.
module muldiv_iter
  import alu_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = $clog2(XLEN) + 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                is_div,
  input  logic                abort,
  input  logic [XLEN-1:0]     opnd_a,
  input  logic [XLEN-1:0]     opnd_b,
  output logic                last,
  output logic [2*XLEN-1:0]   acc_next
);

  logic [CNT_W-1:0]  cnt_q;
  logic [2*XLEN-1:0] acc_q;
  logic [XLEN-1:0]   b_q;
  logic              div_q;

  logic [XLEN:0]     sum;
  logic [XLEN:0]     shl;
  logic [XLEN-1:0]   diff;
  logic              ge;

  always_comb begin
    sum      = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
    shl      = acc_q[2*XLEN-1:XLEN-1];
    ge       = shl >= {1'b0, b_q};
    // Partial remainder stays below the divisor, so the low XLEN bits of the difference suffice.
    diff     = shl[XLEN-1:0] - b_q;
    if (div_q) begin
      acc_next = ge ? {diff, acc_q[XLEN-2:0], 1'b1} : {shl[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
    end else begin
      acc_next = {sum, acc_q[XLEN-1:1]};
    end
  end

  assign last = (cnt_q == CNT_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      acc_q <= '0;
      b_q   <= '0;
      div_q <= 1'b0;
    end else if (start) begin
      cnt_q <= CNT_W'(XLEN);
      acc_q <= {{XLEN{1'b0}}, opnd_a};
      b_q   <= opnd_b;
      div_q <= is_div;
    end else if (abort) begin
      cnt_q <= '0;
    end else if (cnt_q != '0) begin
      acc_q <= acc_next;
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

endmodule

// File: rtl/alu_ctrl_m.sv
// EX-stage ALU controller: base/R-type decode plus an RV32M multiply/divide sequencer that
// stalls the pipeline while the iterative engine runs.
module alu_ctrl_m
  import alu_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid,
  input  logic            flush,
  input  logic [1:0]      ula_op,
  input  logic [6:0]      funct7,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic [3:0]      operation,
  output logic            m_op,
  output logic            err,
  output logic            stall,
  output logic            m_done,
  output logic [XLEN-1:0] m_result
);

  localparam logic [XLEN-1:0] MinInt = {1'b1, {(XLEN-1){1'b0}}};

  m_state_e          state_q;
  logic [2:0]        f3_q;
  logic              res_neg_q;
  logic [XLEN-1:0]   m_result_q;
  logic              m_done_q;

  logic              a_neg, b_neg, res_neg;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic              div_zero, div_ovf, special;
  logic [XLEN-1:0]   special_res;
  logic              accept, start, last;
  logic [2*XLEN-1:0] acc_next, prod;
  logic [XLEN-1:0]   div_raw, final_res;

  always_comb begin
    operation = OpAdd;
    m_op      = 1'b0;
    err       = 1'b0;
    unique case (ula_op)
      UlaAdd:  operation = OpAdd;
      UlaSub:  operation = OpSub;
      UlaRsvd: operation = OpAdd;
      UlaRtype: begin
        if (funct7 == F7MulDiv) begin
          m_op = 1'b1;
        end else if (funct7 == F7Base) begin
          unique case (funct3)
            3'b000: operation = OpAdd;
            3'b001: operation = OpSll;
            3'b010: operation = OpSlt;
            3'b011: operation = OpSltu;
            3'b100: operation = OpXor;
            3'b101: operation = OpSrl;
            3'b110: operation = OpOr;
            3'b111: operation = OpAnd;
          endcase
        end else if (funct7 == F7Alt && funct3 == 3'b000) begin
          operation = OpSub;
        end else if (funct7 == F7Alt && funct3 == 3'b101) begin
          operation = OpSra;
        end else begin
          err = 1'b1;
        end
      end
    endcase
  end

  // The engine works on magnitudes; the sign is restored when the result is captured.
  always_comb begin
    a_neg = (funct3 inside {F3Mulh, F3Mulhsu, F3Div, F3Rem}) & op_a[XLEN-1];
    b_neg = (funct3 inside {F3Mulh, F3Div, F3Rem}) & op_b[XLEN-1];
    a_mag = a_neg ? -op_a : op_a;
    b_mag = b_neg ? -op_b : op_b;
    case (funct3)
      F3Rem:   res_neg = a_neg;
      F3Mul:   res_neg = 1'b0;
      default: res_neg = a_neg ^ b_neg;
    endcase
    div_zero    = (op_b == '0);
    div_ovf     = (funct3 == F3Div || funct3 == F3Rem) && op_a == MinInt && op_b == '1;
    special     = funct3[2] & (div_zero | div_ovf);
    if (funct3[1]) special_res = div_zero ? op_a : '0;
    else           special_res = div_zero ? '1 : op_a;
  end

  always_comb begin
    prod    = res_neg_q ? -acc_next : acc_next;
    div_raw = f3_q[1] ? acc_next[2*XLEN-1:XLEN] : acc_next[XLEN-1:0];
    if (f3_q[2])            final_res = res_neg_q ? -div_raw : div_raw;
    else if (f3_q == F3Mul) final_res = prod[XLEN-1:0];
    else                    final_res = prod[2*XLEN-1:XLEN];
  end

  assign accept = valid & m_op & ~err & ~flush & (state_q == StIdle);
  assign start  = accept & ~special;
  assign stall  = valid & m_op & ~err & (state_q != StDone) & ~flush;
  assign m_done   = m_done_q & ~flush;
  assign m_result = m_result_q;

  muldiv_iter #(
    .XLEN  (XLEN),
    .CNT_W (CNT_W)
  ) u_iter (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .is_div   (funct3[2]),
    .abort    (flush),
    .opnd_a   (a_mag),
    .opnd_b   (b_mag),
    .last     (last),
    .acc_next (acc_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      f3_q       <= '0;
      res_neg_q  <= 1'b0;
      m_result_q <= '0;
      m_done_q   <= 1'b0;
    end else begin
      m_done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            f3_q      <= funct3;
            res_neg_q <= res_neg;
            if (special) begin
              m_result_q <= special_res;
              m_done_q   <= 1'b1;
              state_q    <= StDone;
            end else begin
              state_q <= funct3[2] ? StDiv : StMul;
            end
          end
        end
        StMul, StDiv: begin
          if (flush) begin
            state_q <= StIdle;
          end else if (last) begin
            m_result_q <= final_res;
            m_done_q   <= 1'b1;
            state_q    <= StDone;
          end
        end
        StDone: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_ctrl_m.sv
// Directed bench for alu_ctrl_m: decode, M-op latency/results, special cases, aborts,
// and a 16-bit instance.
module tb_alu_ctrl_m;

  logic        clk = 1'b0;
  logic        rst, valid, flush;
  logic [1:0]  ula_op;
  logic [6:0]  funct7;
  logic [2:0]  funct3;
  logic [31:0] op_a, op_b;
  logic [3:0]  operation;
  logic        m_op, err, stall, m_done;
  logic [31:0] m_result;

  logic        valid16;
  logic [2:0]  funct3_16;
  logic [15:0] op_a16, op_b16;
  logic [3:0]  operation16;
  logic        m_op16, err16, stall16, m_done16;
  logic [15:0] m_result16;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  alu_ctrl_m dut (
    .clk(clk), .rst(rst), .valid(valid), .flush(flush), .ula_op(ula_op), .funct7(funct7),
    .funct3(funct3), .op_a(op_a), .op_b(op_b), .operation(operation), .m_op(m_op),
    .err(err), .stall(stall), .m_done(m_done), .m_result(m_result)
  );

  alu_ctrl_m #(.XLEN(16)) dut16 (
    .clk(clk), .rst(rst), .valid(valid16), .flush(1'b0), .ula_op(2'b10),
    .funct7(7'b0000001), .funct3(funct3_16), .op_a(op_a16), .op_b(op_b16),
    .operation(operation16), .m_op(m_op16), .err(err16), .stall(stall16),
    .m_done(m_done16), .m_result(m_result16)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic dec(input string tag, input logic [1:0] u, input logic [6:0] f7,
                     input logic [2:0] f3, input logic [3:0] e_op, input logic e_m,
                     input logic e_err);
    @(negedge clk);
    valid = ~e_m; ula_op = u; funct7 = f7; funct3 = f3;
    #1;
    chk({tag, "_op"}, operation, e_op);
    chk({tag, "_mop"}, m_op, e_m);
    chk({tag, "_err"}, err, e_err);
    chk({tag, "_stall"}, stall, 1'b0);
  endtask

  // Issue one M instruction, hold it until m_done, check latency, stall count and result.
  task automatic m_run(input string tag, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int lat);
    int n = 0;
    int stalls = 0;
    @(negedge clk);
    valid = 1'b1; ula_op = 2'b10; funct7 = 7'b0000001; funct3 = f3; op_a = a; op_b = b;
    #1;
    while (!m_done && n < 200) begin
      if (stall) stalls++;
      @(negedge clk);
      n++;
    end
    chk({tag, "_lat"}, n, lat);
    chk({tag, "_stalls"}, stalls, lat);
    chk({tag, "_res"}, m_result, exp);
    chk({tag, "_done_stall"}, stall, 1'b0);
    @(negedge clk);
    valid = 1'b0;
    #1;
    chk({tag, "_done_1cyc"}, m_done, 1'b0);
    chk({tag, "_hold"}, m_result, exp);
  endtask

  initial begin
    int n;
    int stalls;
    logic seen;
    rst = 1'b1; valid = 1'b0; flush = 1'b0; ula_op = 2'b00; funct7 = '0; funct3 = '0;
    op_a = '0; op_b = '0;
    valid16 = 1'b0; funct3_16 = '0; op_a16 = '0; op_b16 = '0;
    repeat (2) @(negedge clk);
    chk("rst_done", m_done, 1'b0);
    chk("rst_result", m_result, 32'h0);
    chk("rst_stall_idle", stall, 1'b0);
    valid = 1'b1; ula_op = 2'b10; funct7 = 7'b0000001; funct3 = 3'd0;
    #1;
    chk("rst_stall_comb", stall, 1'b1);
    @(negedge clk);
    valid = 1'b0; rst = 1'b0;

    dec("add",   2'b00, 7'b1111111, 3'd3, 4'd0, 1'b0, 1'b0);
    dec("sub",   2'b01, 7'b0000000, 3'd0, 4'd1, 1'b0, 1'b0);
    dec("rsvd",  2'b11, 7'b0000000, 3'd0, 4'd0, 1'b0, 1'b0);
    dec("sra",   2'b10, 7'b0100000, 3'd5, 4'd7, 1'b0, 1'b0);
    dec("alt1",  2'b10, 7'b0100000, 3'd1, 4'd0, 1'b0, 1'b1);
    dec("rsub",  2'b10, 7'b0100000, 3'd0, 4'd1, 1'b0, 1'b0);
    dec("xor",   2'b10, 7'b0000000, 3'd4, 4'd2, 1'b0, 1'b0);
    dec("sll",   2'b10, 7'b0000000, 3'd1, 4'd5, 1'b0, 1'b0);
    dec("srl",   2'b10, 7'b0000000, 3'd5, 4'd6, 1'b0, 1'b0);
    dec("sltu",  2'b10, 7'b0000000, 3'd3, 4'd9, 1'b0, 1'b0);
    dec("slt",   2'b10, 7'b0000000, 3'd2, 4'd8, 1'b0, 1'b0);
    dec("and",   2'b10, 7'b0000000, 3'd7, 4'd4, 1'b0, 1'b0);
    dec("mdec",  2'b10, 7'b0000001, 3'd6, 4'd0, 1'b1, 1'b0);
    dec("bad7",  2'b10, 7'b0000010, 3'd0, 4'd0, 1'b0, 1'b1);
    @(negedge clk);
    valid = 1'b0;

    m_run("mul",    3'd0, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFE, 33);
    m_run("mulhu",  3'd3, 32'hFFFFFFFF, 32'd2, 32'h00000001, 33);
    m_run("mulh",   3'd1, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 33);
    m_run("mulhsu", 3'd2, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 33);
    m_run("div",    3'd4, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33);
    m_run("rem",    3'd6, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 33);
    m_run("divu",   3'd5, 32'd7, 32'd2, 32'd3, 33);
    m_run("remu",   3'd7, 32'd7, 32'd2, 32'd1, 33);
    m_run("div0",   3'd4, 32'd5, 32'd0, 32'hFFFFFFFF, 1);
    m_run("rem0",   3'd6, 32'd5, 32'd0, 32'd5, 1);
    m_run("divovf", 3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
    m_run("removf", 3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h0, 1);

    // Flush a DIV at its tenth iteration.
    @(negedge clk);
    valid = 1'b1; ula_op = 2'b10; funct7 = 7'b0000001; funct3 = 3'd4;
    op_a = 32'd100; op_b = 32'd3;
    repeat (10) @(negedge clk);
    flush = 1'b1;
    #1;
    chk("flush_stall", stall, 1'b0);
    @(negedge clk);
    flush = 1'b0; valid = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      if (m_done) seen = 1'b1;
      @(negedge clk);
    end
    chk("flush_no_done", seen, 1'b0);
    m_run("mul_after_flush", 3'd0, 32'd12345, 32'd1000, 32'd12345000, 33);

    // Reset in the middle of a MUL.
    @(negedge clk);
    valid = 1'b1; ula_op = 2'b10; funct7 = 7'b0000001; funct3 = 3'd0;
    op_a = 32'd3; op_b = 32'd5;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; valid = 1'b0;
    #1;
    chk("midrst_result", m_result, 32'h0);
    seen = 1'b0;
    repeat (40) begin
      if (m_done) seen = 1'b1;
      @(negedge clk);
    end
    chk("midrst_no_done", seen, 1'b0);
    m_run("mul_after_rst", 3'd0, 32'd3, 32'd5, 32'd15, 33);

    // 16-bit instance: MULHSU 0x8000 * 0xFFFF.
    @(negedge clk);
    valid16 = 1'b1; funct3_16 = 3'd2; op_a16 = 16'h8000; op_b16 = 16'hFFFF;
    #1;
    n = 0; stalls = 0;
    while (!m_done16 && n < 200) begin
      if (stall16) stalls++;
      @(negedge clk);
      n++;
    end
    chk("x16_lat", n, 17);
    chk("x16_stalls", stalls, 17);
    chk("x16_res", m_result16, 16'h8000);
    @(negedge clk);
    valid16 = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
